// File: rtl/mux_scheduler_pkg.sv
// Shared definitions for the analog mux scheduler.
//   state_t    : FSM state encoding
//   idx_width  : width of a slot index for a given number of mux slots (min 1)
//   cnt_width  : width of the shared settle/discharge down-counter
package mux_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SELECT    = 2'd1,
        SAMPLE    = 2'd2,
        DISCHARGE = 2'd3
    } state_t;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // The counter is loaded with (cycles - 1), so it only needs to hold max-1.
    function automatic int cnt_width(input int settle, input int discharge);
        int m;
        m = (settle > discharge) ? settle : discharge;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/mux_slot_finder.sv
// Combinational search for the lowest set bit of a mask above (or, with
// inclusive=1, at or above) a starting slot index.
//   mask        : candidate slots
//   start_index : search origin
//   inclusive   : 1 = the origin itself is a candidate
//   found       : a qualifying bit exists
//   index       : lowest qualifying slot (0 when none found)
module mux_slot_finder
    import mux_scheduler_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]            mask,
    input  logic [idx_width(N)-1:0] start_index,
    input  logic                    inclusive,
    output logic                    found,
    output logic [idx_width(N)-1:0] index
);

    localparam int IDX_W = idx_width(N);

    // Scanning downwards so the last hit written is the lowest qualifying slot.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[i] && ((i > int'(start_index)) ||
                            (inclusive && (i == int'(start_index))))) begin
                found = 1'b1;
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/mux_scheduler.sv
// Analog mux scheduler: walks the enabled mux slots of a frame in ascending
// order, settles each one, samples all comparator lines into pulse_in, then
// discharges the sample/hold before the next frame.
//
// Ports
//   clk           : sampling clock (pll_clk domain)
//   reset         : synchronous, active-high
//   enable        : start or continue framing (checked at frame boundaries)
//   chan_mask     : slot enables, latched at frame start
//   line_in       : comparator inputs
//   mux_out       : one-hot analog mux select, 0 when idle/discharging
//   sh_reset      : sample/hold discharge
//   sample_strobe : one-cycle pulse after pulse_in was updated
//   sample_index  : slot captured at the last sample_strobe
//   pulse_in      : demuxed samples, bit slot*NUM_LINES+line
//   frame_done    : one-cycle pulse after the discharge phase
//   busy          : high in every state except IDLE
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | mux off, S/H discharged, waiting for enable with a mask
// SELECT    | mux driven to current slot, settling for SETTLE_CYCLES
// SAMPLE    | one cycle; comparator lines captured for current slot
// DISCHARGE | mux off, S/H discharged for DISCHARGE_CYCLES, frame end
module mux_scheduler
    import mux_scheduler_pkg::*;
#(
    parameter int MUX_LINES        = 4,
    parameter int NUM_LINES        = 2,
    parameter int SETTLE_CYCLES    = 2,
    parameter int DISCHARGE_CYCLES = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic [MUX_LINES-1:0]           chan_mask,
    input  logic [NUM_LINES-1:0]           line_in,
    output logic [MUX_LINES-1:0]           mux_out,
    output logic                           sh_reset,
    output logic                           sample_strobe,
    output logic [idx_width(MUX_LINES)-1:0] sample_index,
    output logic [NUM_LINES*MUX_LINES-1:0] pulse_in,
    output logic                           frame_done,
    output logic                           busy
);

    localparam int IDX_W = idx_width(MUX_LINES);
    localparam int CNT_W = cnt_width(SETTLE_CYCLES, DISCHARGE_CYCLES);
    localparam logic [CNT_W-1:0] SETTLE_LOAD    = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DISCHARGE_LOAD = CNT_W'(DISCHARGE_CYCLES - 1);

    state_t               state;
    logic [MUX_LINES-1:0] frame_mask;
    logic [IDX_W-1:0]     slot;
    logic [CNT_W-1:0]     cnt;

    logic                 first_found;
    logic [IDX_W-1:0]     first_idx;
    logic                 next_found;
    logic [IDX_W-1:0]     next_idx;
    logic                 start_ok;

    function automatic logic [MUX_LINES-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [MUX_LINES-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Lowest slot of the live mask, used when a new frame is launched.
    mux_slot_finder #(.N(MUX_LINES)) u_first_slot (
        .mask        (chan_mask),
        .start_index ('0),
        .inclusive   (1'b1),
        .found       (first_found),
        .index       (first_idx)
    );

    // Next slot above the current one within the latched frame mask.
    mux_slot_finder #(.N(MUX_LINES)) u_next_slot (
        .mask        (frame_mask),
        .start_index (slot),
        .inclusive   (1'b0),
        .found       (next_found),
        .index       (next_idx)
    );

    assign start_ok = enable && first_found;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            frame_mask    <= '0;
            slot          <= '0;
            cnt           <= '0;
            mux_out       <= '0;
            sh_reset      <= 1'b1;
            sample_strobe <= 1'b0;
            sample_index  <= '0;
            pulse_in      <= '0;
            frame_done    <= 1'b0;
            busy          <= 1'b0;
        end else begin
            sample_strobe <= 1'b0;
            frame_done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        state      <= SELECT;
                        frame_mask <= chan_mask;
                        slot       <= first_idx;
                        cnt        <= SETTLE_LOAD;
                        mux_out    <= onehot(first_idx);
                        sh_reset   <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                SELECT: begin
                    if (cnt == '0) begin
                        state <= SAMPLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                SAMPLE: begin
                    for (int s = 0; s < MUX_LINES; s++) begin
                        for (int x = 0; x < NUM_LINES; x++) begin
                            if (IDX_W'(s) == slot) begin
                                pulse_in[s*NUM_LINES + x] <= line_in[x];
                            end
                        end
                    end
                    sample_index  <= slot;
                    sample_strobe <= 1'b1;
                    if (next_found) begin
                        state   <= SELECT;
                        slot    <= next_idx;
                        cnt     <= SETTLE_LOAD;
                        mux_out <= onehot(next_idx);
                    end else begin
                        // Slot index never wraps directly; a frame always ends here.
                        state    <= DISCHARGE;
                        cnt      <= DISCHARGE_LOAD;
                        mux_out  <= '0;
                        sh_reset <= 1'b1;
                    end
                end
                DISCHARGE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        frame_done <= 1'b1;
                        if (start_ok) begin
                            state      <= SELECT;
                            frame_mask <= chan_mask;
                            slot       <= first_idx;
                            cnt        <= SETTLE_LOAD;
                            mux_out    <= onehot(first_idx);
                            sh_reset   <= 1'b0;
                        end else begin
                            state <= IDLE;
                            slot  <= '0;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scheduler.sv
module tb_mux_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] chan_mask;
    logic [1:0] line_in;
    logic [3:0] mux_out;
    logic       sh_reset;
    logic       sample_strobe;
    logic [1:0] sample_index;
    logic [7:0] pulse_in;
    logic       frame_done;
    logic       busy;

    mux_scheduler dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .chan_mask     (chan_mask),
        .line_in       (line_in),
        .mux_out       (mux_out),
        .sh_reset      (sh_reset),
        .sample_strobe (sample_strobe),
        .sample_index  (sample_index),
        .pulse_in      (pulse_in),
        .frame_done    (frame_done),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        is_done;
        logic [31:0] cycle;
        logic [1:0]  idx;
        logic [7:0]  pulse;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] exp_pulse;
    int         frame_id;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [1:0] slot_val(input int s);
        return 2'(((s + frame_id) % 3) + 1);
    endfunction

    function automatic logic [3:0] onehot4(input int s);
        return 4'(1 << s);
    endfunction

    // Monitor: every strobe / frame_done the DUT presents is matched against
    // the oldest expected event.
    task automatic mon_event(input logic is_done);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: actual kind=%0d at cycle %0d, required none", is_done, cyc);
            return;
        end
        e = exp_q.pop_front();
        check("event_kind", 32'(is_done), 32'(e.is_done));
        check("event_cycle", 32'(cyc), e.cycle);
        if (!is_done && !e.is_done) begin
            check("sample_index", 32'(sample_index), 32'(e.idx));
            check("pulse_in", 32'(pulse_in), 32'(e.pulse));
        end
    endtask

    always @(negedge clk) begin
        if (sample_strobe) mon_event(1'b0);
        if (frame_done)    mon_event(1'b1);
    end

    // Runs one frame starting from the current negedge, where the inputs that
    // launch it are already applied. Expected events are queued up front;
    // per-cycle mux/sh_reset/busy values are checked inline.
    task automatic run_frame(input logic [3:0] fmask, input logic next_en,
                             input logic [3:0] next_mask, input int change_at,
                             input int abort_at);
        int   base;
        int   n;
        int   j;
        int   slots[4];
        ev_t  e;
        logic [1:0] v;
        base = cyc;
        n    = 0;
        frame_id++;
        for (int s = 0; s < 4; s++) begin
            if (fmask[s]) begin
                slots[n] = s;
                n++;
            end
        end
        for (int k = 0; k < n; k++) begin
            if (abort_at == 0 || (4 + 3*k) <= abort_at) begin
                v = slot_val(slots[k]);
                exp_pulse[slots[k]*2 +: 2] = v;
                e.is_done = 1'b0;
                e.cycle   = 32'(base + 4 + 3*k);
                e.idx     = 2'(slots[k]);
                e.pulse   = exp_pulse;
                exp_q.push_back(e);
            end
        end
        if (abort_at == 0) begin
            e.is_done = 1'b1;
            e.cycle   = 32'(base + 2 + 3*n);
            e.idx     = 2'b0;
            e.pulse   = 8'h0;
            exp_q.push_back(e);
        end
        line_in = slot_val(slots[0]);
        for (int t = 1; t <= 3*n + 1; t++) begin
            @(negedge clk);
            if (t <= 3*n) begin
                j = (t - 1) / 3;
                check("mux_out_select", 32'(mux_out), 32'(onehot4(slots[j])));
                check("sh_reset_select", 32'(sh_reset), 32'd0);
                check("busy_select", 32'(busy), 32'd1);
                line_in = slot_val(slots[j]);
            end else begin
                check("mux_out_discharge", 32'(mux_out), 32'd0);
                check("sh_reset_discharge", 32'(sh_reset), 32'd1);
                check("busy_discharge", 32'(busy), 32'd1);
            end
            if (t == change_at) begin
                enable    = next_en;
                chan_mask = next_mask;
            end
            if (t == abort_at) begin
                reset     = 1'b1;
                enable    = 1'b0;
                chan_mask = 4'b0;
                break;
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        chan_mask = 4'b0;
        line_in   = 2'b0;
        exp_pulse = 8'h0;
        frame_id  = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mux_out", 32'(mux_out), 32'd0);
        check("rst_sh_reset", 32'(sh_reset), 32'd1);
        check("rst_pulse_in", 32'(pulse_in), 32'd0);
        check("rst_sample_index", 32'(sample_index), 32'd0);
        check("rst_strobe", 32'(sample_strobe), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        // Enabled with an empty mask: must stay idle.
        enable    = 1'b1;
        chan_mask = 4'b0;
        repeat (20) begin
            @(negedge clk);
            check("empty_mask_busy", 32'(busy), 32'd0);
            check("empty_mask_sh_reset", 32'(sh_reset), 32'd1);
            check("empty_mask_mux_out", 32'(mux_out), 32'd0);
        end

        chan_mask = 4'b1111;
        run_frame(4'b1111, 1'b1, 4'b1111, 13, 0);
        run_frame(4'b1111, 1'b1, 4'b1010, 13, 0);
        run_frame(4'b1010, 1'b1, 4'b1111, 7, 0);
        // Mask changes mid-frame; only the following frame sees it.
        run_frame(4'b1111, 1'b1, 4'b0001, 5, 0);
        run_frame(4'b0001, 1'b1, 4'b1111, 4, 0);
        // Reset during slot 2 SELECT.
        run_frame(4'b1111, 1'b1, 4'b1111, 13, 7);
        @(negedge clk);
        check("abort_mux_out", 32'(mux_out), 32'd0);
        check("abort_sh_reset", 32'(sh_reset), 32'd1);
        check("abort_pulse_in", 32'(pulse_in), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_sample_index", 32'(sample_index), 32'd0);
        exp_pulse = 8'h0;
        reset     = 1'b0;
        @(negedge clk);
        check("post_abort_busy", 32'(busy), 32'd0);

        // Enable dropped mid-frame: frame completes, then idle.
        enable    = 1'b1;
        chan_mask = 4'b0110;
        run_frame(4'b0110, 1'b0, 4'b0110, 2, 0);
        @(negedge clk);
        check("end_busy", 32'(busy), 32'd0);
        check("end_mux_out", 32'(mux_out), 32'd0);
        check("end_sh_reset", 32'(sh_reset), 32'd1);

        repeat (5) @(negedge clk);
        check("pending_events", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_scheduler.md
MUX_SCHEDULER -- requirements
Module: mux_scheduler

Interface
REQ-001 Parameter MUX_LINES, default 4: number of analog mux slots per physical line.
REQ-002 Parameter NUM_LINES, default 2: number of physical comparator lines.
REQ-003 Parameter SETTLE_CYCLES, default 2, minimum 1: cycles the mux is held before a sample.
REQ-004 Parameter DISCHARGE_CYCLES, default 1, minimum 1: cycles sh_reset is held after each frame.
REQ-005 clk  in  1  sampling clock (pll_clk domain).
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 enable  in  1  start or continue framing.
REQ-008 chan_mask  in  MUX_LINES  bit i=1 includes slot i in the frame.
REQ-009 line_in  in  NUM_LINES  comparator inputs.
REQ-010 mux_out  out  MUX_LINES  one-hot analog mux select; 0 when no slot is selected.
REQ-011 sh_reset  out  1  sample/hold discharge.
REQ-012 sample_strobe  out  1  one-cycle pulse when pulse_in has been updated.
REQ-013 sample_index  out  clog2(MUX_LINES) (min 1)  slot captured at the last sample_strobe.
REQ-014 pulse_in  out  NUM_LINES*MUX_LINES  demuxed samples; bit slot*NUM_LINES+line.
REQ-015 frame_done  out  1  one-cycle pulse at the end of the discharge phase.
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 FSM states SHALL be IDLE, SELECT, SAMPLE, DISCHARGE.
REQ-018 IDLE: mux_out=0 and sh_reset=1.
REQ-019 IDLE to SELECT SHALL occur when enable=1 and chan_mask!=0. The FSM latches chan_mask into frame_mask and selects the lowest set slot.
REQ-020 IDLE with enable=1 and chan_mask=0 SHALL remain in IDLE, with no strobe and no frame_done.
REQ-021 SELECT: mux_out=1<<slot, sh_reset=0, and the settle counter counts SETTLE_CYCLES cycles before moving to SAMPLE.
REQ-022 SAMPLE lasts 1 cycle with mux_out held.
REQ-023 At the SAMPLE clock edge, pulse_in[slot*NUM_LINES+x] SHALL take line_in[x] for all x.
REQ-024 At that same edge, sample_index<=slot, and sample_strobe SHALL be high in the following cycle.
REQ-025 After SAMPLE, the FSM SHALL go to SELECT on the next higher set bit of frame_mask, or to DISCHARGE if no higher bit is set.
REQ-026 DISCHARGE: mux_out=0, sh_reset=1, held for DISCHARGE_CYCLES cycles.
REQ-027 frame_done SHALL pulse in the cycle after DISCHARGE exits.
REQ-028 DISCHARGE exit goes to SELECT with a freshly latched chan_mask if enable=1 and chan_mask!=0; otherwise it goes to IDLE.
REQ-029 enable and chan_mask changes SHALL take effect only at frame boundaries; a frame in progress always completes.
REQ-030 Frame length in cycles SHALL be popcount(frame_mask)*(SETTLE_CYCLES+1)+DISCHARGE_CYCLES.
REQ-031 pulse_in bits of unselected slots SHALL retain their previous values.
REQ-032 mux_out SHALL never have more than one bit set.
REQ-033 The slot index SHALL wrap from MUX_LINES-1 only through DISCHARGE, never directly to slot 0.
REQ-034 All outputs SHALL be registered.

Reset
REQ-035 While reset=1: state=IDLE, mux_out=0, sh_reset=1, pulse_in=0, sample_index=0, sample_strobe=0, frame_done=0, busy=0, and all counters cleared.
REQ-036 Reset asserted mid-frame SHALL abort the frame at the next edge with no frame_done.
REQ-037 Reset SHALL take priority over every other input.

Structure
REQ-038 A shared package SHALL hold the FSM state encoding and the slot-index width function.
REQ-039 Slot search SHALL be a sub-module mux_slot_finder: combinational next-set-bit search above a given index, returning found and index.
REQ-040 The settle/discharge counter SHALL be a single shared down-counter, loaded at each state entry.

Verification
Benches use defaults unless stated.
REQ-041 enable=1, mask=1111 -> mux_out sequence 0001,0010,0100,1000, each held 3 cycles; sh_reset high 1 cycle; frame_done every 13 cycles.
REQ-042 mask=1010, line_in toggling per slot -> only slots 1 and 3 are selected; frame is 7 cycles; pulse_in bits 0,1,4,5 are unchanged.
REQ-043 mask changed 1111->0001 mid-frame -> current frame completes at 13 cycles; next frame selects only slot 0 and is 4 cycles.
REQ-044 reset pulsed during slot 2 SELECT -> next cycle mux_out=0, sh_reset=1, pulse_in=0, no frame_done.
REQ-045 enable=1, mask=0000 -> stays IDLE for 20 cycles, busy=0, sh_reset=1, no strobes.
REQ-046 enable dropped mid-frame -> frame completes; frame_done pulses; FSM then enters IDLE with busy=0.
